// File: rtl/pc_reg_pkg.sv
// Shared constants for the program-counter register with return stack:
// operation-mode encodings and sticky error-bit positions.
package pc_reg_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_INCR   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_CALL   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_RET    = 3'd4;
    localparam logic [MODE_W-1:0] MODE_PRESET = 3'd5;

    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UNF = 1;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. Push when full and pop when empty are ignored and
// flagged on o_ovf_c / o_unf_c. Level, full and empty are registered; the
// RAM itself is never cleared by reset.
module pc_return_stack #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [Width-1:0]             i_data,
    output logic [Width-1:0]             o_top_c,
    output logic [$clog2(Depth+1)-1:0]   o_level,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_ovf_c,
    output logic                         o_unf_c
);

    localparam int unsigned LW = $clog2(Depth + 1);
    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    // Push wins if both are requested; the caller never asserts both.
    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~i_push & ~r_empty;
    assign w_wr_idx  = AW'(r_level);
    assign w_rd_idx  = AW'(r_level - LW'(1));

    assign o_top_c = r_mem[w_rd_idx];
    assign o_ovf_c = i_push & r_full;
    assign o_unf_c = i_pop & ~i_push & r_empty;
    assign o_level = r_level;
    assign o_full  = r_full;
    assign o_empty = r_empty;

    // Next occupancy: moves by at most one entry per edge.
    always_comb begin
        w_level_nxt = r_level;
        if (w_do_push) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_do_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // Occupancy and its decoded flags, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(Depth));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Entry storage; a reset on the same edge discards the push.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_register_stack.sv
// Program-counter register with return-address LIFO and tristate Q.
// Modes: hold, load, increment, call, return, preset (6/7 act as hold).
// Optional build macro PC_STACK_ERR_EN adds the sticky StackErr port.
module pc_register_stack #(
    parameter int unsigned NrOfBits   = 16,
    parameter int unsigned StepSize   = 1,
    parameter int unsigned ResetValue = 0,
    parameter int unsigned StackDepth = 4
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              ClockEnable,
    input  logic                              Tick,
    input  logic [2:0]                        Mode,
    input  logic [NrOfBits-1:0]               D,
    input  logic                              cs,
    output logic [NrOfBits-1:0]               Q,
    output logic [$clog2(StackDepth+1)-1:0]   StackLevel,
    output logic                              StackEmpty,
    output logic                              StackFull
`ifdef PC_STACK_ERR_EN
    ,
    output logic [1:0]                        StackErr
`endif
);

    import pc_reg_pkg::*;

    localparam int unsigned LW = $clog2(StackDepth + 1);

    logic [NrOfBits-1:0] r_pc;
    logic [NrOfBits-1:0] w_pc_nxt;
    logic [NrOfBits-1:0] w_pc_inc;
    logic [NrOfBits-1:0] w_top;
    logic                w_update;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf;
    logic                w_unf;
    logic                w_empty;
    logic                w_full;
    logic [LW-1:0]       w_level;

    assign w_update = ClockEnable & Tick;
    assign w_pc_inc = r_pc + NrOfBits'(StepSize);

    // Mode decode: next PC and stack request for this edge.
    always_comb begin
        w_pc_nxt = r_pc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (w_update) begin
            case (Mode)
                MODE_LOAD:   w_pc_nxt = D;
                MODE_INCR:   w_pc_nxt = w_pc_inc;
                MODE_CALL: begin
                    w_push   = 1'b1;
                    w_pc_nxt = D;
                end
                MODE_RET: begin
                    w_pop = 1'b1;
                    if (!w_empty) begin
                        w_pc_nxt = w_top;
                    end
                end
                MODE_PRESET: w_pc_nxt = '1;
                default:     w_pc_nxt = r_pc;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc <= NrOfBits'(ResetValue);
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    pc_return_stack #(
        .Width (NrOfBits),
        .Depth (StackDepth)
    ) u_stack (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top_c (w_top),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ovf_c (w_ovf),
        .o_unf_c (w_unf)
    );

    assign StackLevel = w_level;
    assign StackEmpty = w_empty;
    assign StackFull  = w_full;

    // Deselect only floats the bus; the PC keeps running.
    assign Q = cs ? {NrOfBits{1'bz}} : r_pc;

`ifdef PC_STACK_ERR_EN
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_set;

    // Map stack misuse onto the error-bit positions.
    always_comb begin
        w_err_set          = '0;
        w_err_set[ERR_OVF] = w_ovf;
        w_err_set[ERR_UNF] = w_unf;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | w_err_set;
        end
    end

    assign StackErr = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = w_ovf | w_unf;
`endif

endmodule
